// File: rtl/xor_tt_sequencer.sv
// xor_tt_sequencer
// Steps an external combinational gate-under-test through every minterm of
// its inputs, compares each settled output against a golden truth table and
// records per-minterm failures, a mismatch count and the first failing index.
//
// Build option: define STOP_ON_FAIL_EN to end the sweep at the first mismatch.
//
// Parameters:
//   N_IN          number of gate inputs (1..4), M = 2**N_IN minterms
//   EXPECTED      golden output per minterm, bit m for input value m
//   SETTLE_CYCLES wait cycles between applying inputs and sampling (0..15)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   start          begin a sweep (honoured only in IDLE or DONE)
//   abort          stop a running sweep, return to IDLE without done
//   dut_in         input vector driven to the gate-under-test
//   dut_out        output of the gate-under-test
//   busy           high while applying / waiting / checking
//   done           high in DONE until the next start or reset
//   minterm        current minterm index
//   fail_mask      bit m set if minterm m mismatched
//   mismatch_cnt   number of mismatches (0..M)
//   first_fail     index of the first mismatch
//   first_fail_vld first_fail holds a valid index
module xor_tt_sequencer #(
  parameter int unsigned               N_IN          = 2,
  parameter logic [(2**N_IN)-1:0]      EXPECTED      = 4'b0110,
  parameter int unsigned               SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [N_IN-1:0]        minterm,
  output logic [(2**N_IN)-1:0]   fail_mask,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_vld
);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [N_IN-1:0] MINT_ONE = 1;
  localparam logic [N_IN:0]   CNT_ONE  = 1;
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             settle_q;
  logic [N_IN-1:0]        minterm_q;
  logic [(2**N_IN)-1:0]   fail_mask_q;
  logic [N_IN:0]          mismatch_cnt_q;
  logic [N_IN-1:0]        first_fail_q;
  logic                   first_fail_vld_q;

  logic mismatch;
  logic clear_res;
  logic record_fail;
  logic advance;

  // Case-inequality so an X/Z from the gate counts as a mismatch in simulation.
  always_comb begin
    mismatch = (dut_out !== EXPECTED[minterm_q]);
  end

  always_comb begin
    state_d     = state_q;
    clear_res   = 1'b0;
    record_fail = 1'b0;
    advance     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // abort beats start when both arrive outside a sweep
        if (start && abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d   = S_APPLY;
          clear_res = 1'b1;
        end
      end
      S_APPLY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (SETTLE_CYCLES == 0) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q <= 4'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          record_fail = mismatch;
          if ((minterm_q == '1) || (STOP_ON_FAIL && mismatch)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_APPLY;
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      settle_q         <= '0;
      minterm_q        <= '0;
      fail_mask_q      <= '0;
      mismatch_cnt_q   <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_APPLY) begin
        settle_q <= SETTLE_LOAD;
      end else if (state_q == S_WAIT) begin
        settle_q <= settle_q - 4'd1;
      end

      if (clear_res) begin
        minterm_q        <= '0;
        fail_mask_q      <= '0;
        mismatch_cnt_q   <= '0;
        first_fail_q     <= '0;
        first_fail_vld_q <= 1'b0;
      end

      if (record_fail) begin
        fail_mask_q[minterm_q] <= 1'b1;
        mismatch_cnt_q         <= mismatch_cnt_q + CNT_ONE;
        if (!first_fail_vld_q) begin
          first_fail_q     <= minterm_q;
          first_fail_vld_q <= 1'b1;
        end
      end

      if (advance) begin
        minterm_q <= minterm_q + MINT_ONE;
      end
    end
  end

  always_comb begin
    busy           = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
    done           = (state_q == S_DONE);
    // minterm register is held across an abort, but the gate sees 0 when idle
    dut_in         = (state_q == S_IDLE) ? '0 : minterm_q;
    minterm        = minterm_q;
    fail_mask      = fail_mask_q;
    mismatch_cnt   = mismatch_cnt_q;
    first_fail     = first_fail_q;
    first_fail_vld = first_fail_vld_q;
  end

endmodule

// File: tb/tb_xor_tt_sequencer.sv
// Bench for xor_tt_sequencer: two instances (XOR golden with one settle cycle,
// XNOR golden with no settle cycle) share start/abort/reset and each drive a
// bench-side gate (NOR-built XOR, stuck-at-0, stuck-at-1 or a random table).
// A time-indexed sweep model predicts every output each cycle.
module tb_xor_tt_sequencer;

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [3:0] EXP0 = 4'b0110;
  localparam logic [3:0] EXP1 = 4'b1001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort;
  logic [1:0]      dut_out_w, busy_w, done_w, ffv_w;
  logic [1:0][1:0] din_w, mint_w, ff_w;
  logic [1:0][3:0] mask_w;
  logic [1:0][2:0] cnt_w;

  int unsigned mode [2];
  logic [3:0]  tt   [2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  xor_tt_sequencer #(.N_IN(2), .EXPECTED(EXP0), .SETTLE_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(din_w[0]), .dut_out(dut_out_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .minterm(mint_w[0]), .fail_mask(mask_w[0]), .mismatch_cnt(cnt_w[0]),
    .first_fail(ff_w[0]), .first_fail_vld(ffv_w[0])
  );

  xor_tt_sequencer #(.N_IN(2), .EXPECTED(EXP1), .SETTLE_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(din_w[1]), .dut_out(dut_out_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .minterm(mint_w[1]), .fail_mask(mask_w[1]), .mismatch_cnt(cnt_w[1]),
    .first_fail(ff_w[1]), .first_fail_vld(ffv_w[1])
  );

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // mode 0: XOR from four NORs plus an inverting NOR; 1: stuck-0; 2: stuck-1; 3: table
  function automatic logic gate(input int unsigned md, input logic [3:0] t, input logic [1:0] x);
    logic n1, n2, n3, n4;
    n1 = nor2(x[1], x[0]);
    n2 = nor2(x[1], n1);
    n3 = nor2(x[0], n1);
    n4 = nor2(n2, n3);
    case (md)
      0:       return nor2(n4, n4);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return t[x];
    endcase
  endfunction

  always_comb dut_out_w[0] = gate(mode[0], tt[0], din_w[0]);
  always_comb dut_out_w[1] = gate(mode[1], tt[1], din_w[1]);

  // ---------------- reference model ----------------
  bit          m_busy [2];
  bit          m_done [2];
  int unsigned m_t    [2];
  logic [1:0]  m_mint [2];
  logic [3:0]  m_mask [2];
  logic [2:0]  m_cnt  [2];
  logic [1:0]  m_ff   [2];
  logic        m_ffv  [2];

  function automatic bit fails(input int i, input int m);
    logic [3:0] e;
    e = (i == 0) ? EXP0 : EXP1;
    return gate(mode[i], tt[i], 2'(m)) != e[m];
  endfunction

  // results after the first c minterms of the sweep have been checked
  function automatic void summarize(input int i, input int c);
    m_mask[i] = '0; m_cnt[i] = '0; m_ff[i] = '0; m_ffv[i] = 1'b0;
    for (int m = 0; m < c; m++) begin
      if (fails(i, m)) begin
        m_mask[i][m] = 1'b1;
        m_cnt[i]     = m_cnt[i] + 3'd1;
        if (!m_ffv[i]) begin
          m_ff[i]  = 2'(m);
          m_ffv[i] = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int p, m;
      p = (i == 0) ? 3 : 2;   // cycles per minterm: settle + apply + check
      if (reset) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0; m_mint[i] = '0;
        summarize(i, 0);
      end else if (m_busy[i]) begin
        if (abort) begin
          m_busy[i] = 1'b0;
        end else begin
          m = int'(m_t[i]) / p;
          if (int'(m_t[i]) % p == p - 1) begin
            summarize(i, m + 1);
            if (m == 3 || (STOP && fails(i, m))) begin
              m_busy[i] = 1'b0; m_done[i] = 1'b1; m_mint[i] = 2'(m);
            end else begin
              m_t[i]++; m_mint[i] = 2'(m + 1);
            end
          end else begin
            m_t[i]++;
          end
        end
      end else begin
        if (start && abort) begin
          m_done[i] = 1'b0;
        end else if (start) begin
          summarize(i, 0);
          m_busy[i] = 1'b1; m_done[i] = 1'b0; m_t[i] = 0; m_mint[i] = '0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] got, exp;
        logic [1:0]  edin;
        edin = (m_busy[i] || m_done[i]) ? m_mint[i] : 2'b00;
        got = {busy_w[i], done_w[i], mint_w[i], din_w[i], mask_w[i], cnt_w[i], ff_w[i], ffv_w[i]};
        exp = {m_busy[i], m_done[i], m_mint[i], edin, m_mask[i], m_cnt[i], m_ff[i], m_ffv[i]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_model inst%0d t=%0t got={busy,done,mint,din,mask,cnt,ff,ffv}=%h need=%h",
                   i, $time, got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d need=%0d", name, got, exp);
    end
  endtask

  // start sampled at the next rising edge (E0); returns at the falling edge after E0
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
  endtask

  // edges after E0 at which each instance shows done; 0 if the budget expires
  task automatic run_to_done(output int d0, output int d1);
    d0 = 0; d1 = 0;
    for (int k = 1; k <= 40 && (d0 == 0 || d1 == 0); k++) begin
      @(negedge clk);
      if (done_w[0] && d0 == 0) d0 = k;
      if (done_w[1] && d1 == 0) d1 = k;
    end
  endtask

  initial begin
    int d0, d1;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    mode[0] = 0; mode[1] = 0; tt[0] = '0; tt[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outs0", {busy_w[0], done_w[0], mint_w[0], din_w[0], mask_w[0], cnt_w[0], ff_w[0], ffv_w[0]}, 0);
    reset = 1'b0;

    // correct XOR on both: XOR golden passes, XNOR golden fails everywhere
    pulse_start();
    run_to_done(d0, d1);
    chk("A_done_edge0", d0, 12);
    chk("A_done_edge1", d1, STOP ? 2 : 8);
    chk("A_mask0", mask_w[0], 0);
    chk("A_cnt0", cnt_w[0], 0);
    chk("A_ffv0", ffv_w[0], 0);
    chk("A_din0_held", din_w[0], 3);
    chk("A_mask1", mask_w[1], STOP ? 4'b0001 : 4'b1111);
    chk("A_cnt1", cnt_w[1], STOP ? 1 : 4);
    chk("A_ff1", {ffv_w[1], ff_w[1]}, 3'b100);

    // stuck-at-0 against XOR golden
    mode[0] = 1;
    pulse_start();
    run_to_done(d0, d1);
    chk("B_done_edge0", d0, STOP ? 6 : 12);
    chk("B_mask0", mask_w[0], STOP ? 4'b0010 : 4'b0110);
    chk("B_cnt0", cnt_w[0], STOP ? 1 : 2);
    chk("B_ff0", {ffv_w[0], ff_w[0]}, 3'b101);

    // stuck-at-1 against XOR golden
    mode[0] = 2;
    pulse_start();
    run_to_done(d0, d1);
    chk("C_done_edge0", d0, STOP ? 3 : 12);
    chk("C_mint0", mint_w[0], STOP ? 0 : 3);
    chk("C_mask0", mask_w[0], STOP ? 4'b0001 : 4'b1001);
    chk("C_cnt0", cnt_w[0], STOP ? 1 : 2);
    chk("C_ff0", {ffv_w[0], ff_w[0]}, 3'b100);

    // reset at E5 mid-sweep, restart at E7, done at E19
    mode[0] = 0;
    pulse_start();
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("D_reset_outs0", {busy_w[0], done_w[0], mint_w[0], din_w[0], mask_w[0], cnt_w[0], ff_w[0], ffv_w[0]}, 0);
    chk("D_reset_outs1", {busy_w[1], done_w[1], mint_w[1], din_w[1], mask_w[1], cnt_w[1], ff_w[1], ffv_w[1]}, 0);
    reset = 1'b0;
    @(posedge clk);
    pulse_start();
    run_to_done(d0, d1);
    chk("D_done_edge0", d0, 12);
    chk("D_mask0", mask_w[0], 0);

    // start at E3 while busy (ignored), abort at E6
    mode[0] = 2;
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk) abort = 1'b0;
    chk("E_busy0", busy_w[0], 0);
    chk("E_done0", done_w[0], STOP ? 1 : 0);
    chk("E_mask0", mask_w[0], 4'b0001);
    chk("E_cnt0", cnt_w[0], 1);
    chk("E_mint0", mint_w[0], STOP ? 0 : 1);
    chk("E_din0", din_w[0], 0);
    chk("E_busy1", busy_w[1], 0);

    // random traffic with random gate behaviour, changed only between sweeps
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom % 64) == 0;
      start = ($urandom % 6) == 0;
      abort = ($urandom % 40) == 0;
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i] && ($urandom % 4) == 0) begin
          mode[i] = $urandom % 4;
          tt[i]   = 4'($urandom);
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_tt_sequencer.md
Name: xor_tt_sequencer

Overview:
Clocked controller that sequences an external combinational gate-under-test (e.g. the NOR-built 2-input XOR cell) through every minterm of its inputs. It compares each settled output against a golden truth-table mask and reports per-minterm pass/fail, a mismatch count and the first failing minterm. It sits between the bench/top level and the gate network, and replaces the hand-written #1 stimulus chains used for truth-table checks.

Parameters:
N_IN, 2, number of gate inputs (1..4); minterm count M = 2**N_IN
EXPECTED, 4'b0110, golden output per minterm, width M; bit m = expected output for input value m (default = XOR)
SETTLE_CYCLES, 1, wait cycles between applying inputs and sampling (0..15; 0 = no wait state)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
abort  input  1  stop sweep, return to IDLE, no done
dut_in  output  N_IN  input vector driven to gate-under-test
dut_out  input  1  output of gate-under-test
busy  output  1  high in APPLY/WAIT/CHECK
done  output  1  high in DONE until next start or reset
minterm  output  N_IN  current minterm index
fail_mask  output  M  bit m set if minterm m mismatched
mismatch_cnt  output  N_IN+1  number of mismatches (0..M)
first_fail  output  N_IN  index of first mismatch
first_fail_vld  output  1  first_fail holds a valid index

Behaviour:
- Reset (sync, active-high): state=IDLE; every output is 0 after the reset edge. Reset overrides start/abort. Reset mid-sweep discards all results.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE + start=1: clear fail_mask, mismatch_cnt, first_fail, first_fail_vld and done; minterm=0; go to APPLY.
- APPLY (1 cycle): dut_in=minterm; load settle counter with SETTLE_CYCLES; go to WAIT (or to CHECK if SETTLE_CYCLES=0).
- WAIT: decrement the counter each cycle; go to CHECK on the cycle the counter reaches 1. Lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): sample dut_out. On mismatch with EXPECTED[minterm], on the next edge:
  - set fail_mask[minterm]
  - mismatch_cnt += 1
  - if first_fail_vld=0, set first_fail=minterm and first_fail_vld=1.
  - Then: if minterm == M-1, go to DONE; else minterm += 1 (no wrap) and go to APPLY.
- dut_in holds its value from APPLY through CHECK and keeps the last value in DONE. It returns to 0 in IDLE.
- Per-minterm cost is SETTLE_CYCLES+2 cycles. With start sampled at edge E0, done rises at edge E0 + M*(SETTLE_CYCLES+2). Defaults: E12.
- start while busy: ignored.
- abort while busy: IDLE on the next edge. Results are held and done stays 0. abort in IDLE/DONE has no effect. start and abort together in IDLE/DONE: abort wins, stay/go IDLE.
- DONE: results stable; done=1; busy=0.
- dut_out X/Z in simulation counts as a mismatch (case-inequality compare).
- mismatch_cnt saturates naturally at M; no overflow is possible.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: a mismatch in CHECK goes straight to DONE after the bookkeeping update. minterm and dut_in hold the failing index; mismatch_cnt is 1 at done.
- Undefined: the full sweep always runs, as described in Behaviour.

Test Plan:
- Correct NOR-based XOR as DUT, defaults, start pulse at E0 -> dut_in steps 00,01,10,11; done=1 at E12; fail_mask=0000; mismatch_cnt=0; first_fail_vld=0.
- DUT stuck-at-0, defaults -> fail_mask=0110; mismatch_cnt=2; first_fail=1; first_fail_vld=1.
- EXPECTED=4'b1001 (XNOR), SETTLE_CYCLES=0, correct XOR DUT -> fail_mask=1111; mismatch_cnt=4; first_fail=0; done at E8.
- Reset asserted at E5 mid-sweep, then start at E7 -> all outputs 0 after E5; new sweep completes with done at E19 and correct results.
- start pulsed at E3 while busy; abort at E6 -> start ignored; IDLE after E6 with busy=0, done=0; partial fail_mask retained.
- STOP_ON_FAIL_EN defined, DUT stuck-at-1 -> done at E3; minterm=0; fail_mask=0001; mismatch_cnt=1; first_fail=0.
